// File: rtl/keccak_axil_master.sv
// AXI4-Lite initiator that sequences the SHA-3 peripheral: reset, configure,
// feed message words, poll STATUS, then stream the digest words out.
module keccak_axil_master #(
    parameter int          ADDR_WIDTH = 7,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic                  start,
    input  logic [1:0]            out_size,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    input  logic [1:0]            in_nbytes,
    output logic                  dig_valid,
    input  logic                  dig_ready,
    output logic [31:0]           dig_data,
    output logic                  dig_last,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);
    // state       | meaning
    // S_IDLE      | waiting for start
    // S_CMD_RST   | write COMMAND <- 1 (peripheral reset)
    // S_CTRL_INIT | write CONTROL <- out_size<<4
    // S_WAIT_IN   | in_ready high, accept one message word
    // S_CTRL_LAST | write CONTROL with last flag and byte count
    // S_WR_INPUT  | write INPUT <- accepted word
    // S_POLL      | read STATUS until bit0 is set
    // S_RD_OUT    | read OUTPUT word cnt
    // S_EMIT      | present digest word on dig_*
    // S_DONE      | one-cycle done pulse
    typedef enum logic [3:0] {
        S_IDLE, S_CMD_RST, S_CTRL_INIT, S_WAIT_IN, S_CTRL_LAST,
        S_WR_INPUT, S_POLL, S_RD_OUT, S_EMIT, S_DONE
    } state_t;

    localparam int unsigned OFF_CONTROL = 32'h00;
    localparam int unsigned OFF_STATUS  = 32'h04;
    localparam int unsigned OFF_INPUT   = 32'h08;
    localparam int unsigned OFF_COMMAND = 32'h0C;
    localparam int unsigned OFF_OUTPUT  = 32'h10;

    state_t                r_state, w_state_nxt;
    logic                  r_issued;
    logic                  r_busy, r_done, r_error;
    logic                  r_in_ready;
    logic [31:0]           r_data;
    logic                  r_last;
    logic [1:0]            r_nbytes;
    logic [1:0]            r_size;
    logic [3:0]            r_cnt;
    logic                  r_dig_valid, r_dig_last;
    logic [31:0]           r_dig_data;
    logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [31:0]           r_wdata;

    logic                  w_b_hs, w_r_hs, w_in_hs, w_dig_hs;
    logic                  w_is_wr, w_is_rd;
    logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
    logic [31:0]           w_wr_data;
    logic [4:0]            w_nwords;

    assign w_b_hs   = M_AXI_BVALID & r_bready;
    assign w_r_hs   = M_AXI_RVALID & r_rready;
    assign w_in_hs  = in_valid & r_in_ready;
    assign w_dig_hs = r_dig_valid & dig_ready;
    assign w_is_wr  = (r_state == S_CMD_RST) || (r_state == S_CTRL_INIT) ||
                      (r_state == S_CTRL_LAST) || (r_state == S_WR_INPUT);
    assign w_is_rd  = (r_state == S_POLL) || (r_state == S_RD_OUT);

    always_comb begin
        w_nwords = 5'd16;
        case (r_size)
            2'd0: w_nwords = 5'd16;
            2'd1: w_nwords = 5'd12;
            2'd2: w_nwords = 5'd8;
            2'd3: w_nwords = 5'd7;
            default: w_nwords = 5'd16;
        endcase
    end

    always_comb begin
        w_wr_addr = ADDR_WIDTH'(BASE_ADDR + OFF_INPUT);
        w_wr_data = r_data;
        case (r_state)
            S_CMD_RST: begin
                w_wr_addr = ADDR_WIDTH'(BASE_ADDR + OFF_COMMAND);
                w_wr_data = 32'd1;
            end
            S_CTRL_INIT: begin
                w_wr_addr = ADDR_WIDTH'(BASE_ADDR + OFF_CONTROL);
                w_wr_data = 32'({r_size, 4'b0000});
            end
            S_CTRL_LAST: begin
                w_wr_addr = ADDR_WIDTH'(BASE_ADDR + OFF_CONTROL);
                w_wr_data = 32'({r_size, 2'b01, r_nbytes});
            end
            default: ;
        endcase
    end

    assign w_rd_addr = (r_state == S_POLL) ? ADDR_WIDTH'(BASE_ADDR + OFF_STATUS)
                     : ADDR_WIDTH'(BASE_ADDR + OFF_OUTPUT + 32'({r_cnt, 2'b00}));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_CMD_RST;
            S_CMD_RST:   if (w_b_hs) w_state_nxt = S_CTRL_INIT;
            S_CTRL_INIT: if (w_b_hs) w_state_nxt = S_WAIT_IN;
            S_WAIT_IN:   if (w_in_hs) w_state_nxt = in_last ? S_CTRL_LAST : S_WR_INPUT;
            S_CTRL_LAST: if (w_b_hs) w_state_nxt = S_WR_INPUT;
            S_WR_INPUT:  if (w_b_hs) w_state_nxt = r_last ? S_POLL : S_WAIT_IN;
            S_POLL:      if (w_r_hs && M_AXI_RDATA[0]) w_state_nxt = S_RD_OUT;
            S_RD_OUT:    if (w_r_hs) w_state_nxt = S_EMIT;
            S_EMIT:      if (w_dig_hs) w_state_nxt = r_dig_last ? S_DONE : S_RD_OUT;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_issued    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_nbytes    <= '0;
            r_size      <= '0;
            r_cnt       <= '0;
            r_dig_valid <= 1'b0;
            r_dig_last  <= 1'b0;
            r_dig_data  <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_in_ready <= (w_state_nxt == S_WAIT_IN);

            if (r_state == S_IDLE && start) begin
                r_busy  <= 1'b1;
                r_error <= 1'b0;
                r_size  <= out_size;
                r_cnt   <= '0;
            end
            if (r_state == S_DONE) r_busy <= 1'b0;

            if (r_state == S_WAIT_IN && w_in_hs) begin
                r_data   <= in_data;
                r_last   <= in_last;
                r_nbytes <= in_nbytes;
            end

            // Issue one transaction per state visit; the handshake re-arms it.
            if (w_is_wr && !r_issued) begin
                r_issued  <= 1'b1;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_bready  <= 1'b1;
                r_awaddr  <= w_wr_addr;
                r_wdata   <= w_wr_data;
            end
            if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
            if (w_b_hs) begin
                r_bready <= 1'b0;
                r_issued <= 1'b0;
                if (M_AXI_BRESP != 2'b00) r_error <= 1'b1;
            end

            if (w_is_rd && !r_issued) begin
                r_issued  <= 1'b1;
                r_arvalid <= 1'b1;
                r_rready  <= 1'b1;
                r_araddr  <= w_rd_addr;
            end
            if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
            if (w_r_hs) begin
                r_rready <= 1'b0;
                r_issued <= 1'b0;
                if (M_AXI_RRESP != 2'b00) r_error <= 1'b1;
                if (r_state == S_POLL && M_AXI_RDATA[0]) r_cnt <= '0;
                if (r_state == S_RD_OUT) begin
                    r_dig_data  <= M_AXI_RDATA;
                    r_dig_valid <= 1'b1;
                    r_dig_last  <= ({1'b0, r_cnt} == w_nwords - 5'd1);
                end
            end

            if (r_state == S_EMIT && w_dig_hs) begin
                r_dig_valid <= 1'b0;
                r_dig_last  <= 1'b0;
                r_cnt       <= r_cnt + 4'd1;
                if (r_dig_last) r_done <= 1'b1;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign in_ready      = r_in_ready;
    assign dig_valid     = r_dig_valid;
    assign dig_data      = r_dig_data;
    assign dig_last      = r_dig_last;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
endmodule
